// File: rtl/jtframe_prog_pkg.sv
// rtl/jtframe_prog_pkg.sv - shared types and constants for the ROM-download staging path
package jtframe_prog_pkg;

   localparam logic [1:0] MASK_LO  = 2'b10;
   localparam logic [1:0] MASK_HI  = 2'b01;
   localparam logic [1:0] MASK_OFF = 2'b11;

   typedef struct packed {
      logic [1:0]  bank;
      logic [21:0] addr;
      logic [1:0]  mask;
      logic [7:0]  data;
   } prog_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      GAP
   } prog_state_t;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// rtl/jtframe_prog_fifo.sv - synchronous FIFO of prog_entry_t, push on full is legal with a pop
module jtframe_prog_fifo
   import jtframe_prog_pkg::*;
#(
   parameter int AW = 3
)(
   input  logic        clk_rom,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  prog_entry_t din,
   output prog_entry_t dout,
   output logic        full,
   output logic        empty
);

   prog_entry_t   mem [2**AW];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = wr_ptr == rd_ptr;
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // On full, the slot being overwritten is the head that the reader is retiring
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_rom) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk_rom) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/jtframe_prog_pack.sv
// rtl/jtframe_prog_pack.sv - ioctl byte stream to SDRAM prog_* writes; JTFRAME_PROG_SUM_EN adds prog_sum
module jtframe_prog_pack
   import jtframe_prog_pkg::*;
#(
   parameter int          HEADER    = 0,
   parameter logic [24:0] BA1_START = 25'h10_0000,
   parameter logic [24:0] BA2_START = 25'h20_0000,
   parameter logic [24:0] BA3_START = 25'h30_0000,
   parameter int          SWAB      = 0,
   parameter int          FIFO_AW   = 3
)(
   input  logic        clk_rom,
   input  logic        rst_n,
   input  logic        downloading,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   output logic [21:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_bank,
   output logic        prog_we,
   input  logic        prog_rdy,
   output logic        dwnld_busy,
   output logic        dropped
`ifdef JTFRAME_PROG_SUM_EN
   ,
   output logic [15:0] prog_sum
`endif
);

   localparam logic [24:0] HDR    = HEADER[24:0];
   localparam logic        SWAB_B = SWAB != 0;

   prog_state_t state;
   prog_entry_t fifo_din, fifo_dout, out_q;
   logic        fifo_full, fifo_empty, push, pop;
   logic        dl_q, dl_rise, hdr_skip, wr_ok, ovf, drop_now;
   logic [24:0] a, base, off;
   logic [1:0]  bank;

   always_comb begin
      {hdr_skip, a} = {1'b0, ioctl_addr} - {1'b0, HDR};
      if (a >= BA3_START) begin
         bank = 2'd3;
         base = BA3_START;
      end else if (a >= BA2_START) begin
         bank = 2'd2;
         base = BA2_START;
      end else if (a >= BA1_START) begin
         bank = 2'd1;
         base = BA1_START;
      end else begin
         bank = 2'd0;
         base = '0;
      end
      off           = a - base;
      ovf           = |off[24:23];
      fifo_din.bank = bank;
      fifo_din.addr = off[22:1];
      fifo_din.mask = (off[0] ^ SWAB_B) ? MASK_HI : MASK_LO;
      fifo_din.data = ioctl_data;
   end

   assign dl_rise  = downloading && !dl_q;
   assign wr_ok    = ioctl_wr && downloading && !hdr_skip;
   assign pop      = (state == WRITE) && prog_we && prog_rdy;
   assign push     = wr_ok && !ovf && (!fifo_full || pop);
   assign drop_now = wr_ok && (ovf || (fifo_full && !pop));

   assign {prog_bank, prog_addr, prog_mask, prog_data} = out_q;

   jtframe_prog_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk_rom (clk_rom),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .din     (fifo_din),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Entering from IDLE spends one WRITE cycle loading the head; GAP reloads directly
   always_ff @(posedge clk_rom) begin
      if (!rst_n) begin
         state   <= IDLE;
         prog_we <= 1'b0;
         out_q   <= '{bank: 2'd0, addr: 22'd0, mask: MASK_OFF, data: 8'd0};
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) state <= WRITE;
            end
            WRITE: begin
               if (!prog_we) begin
                  out_q   <= fifo_dout;
                  prog_we <= 1'b1;
               end else if (prog_rdy) begin
                  prog_we <= 1'b0;
                  state   <= GAP;
               end
            end
            GAP: begin
               if (!fifo_empty) begin
                  out_q   <= fifo_dout;
                  prog_we <= 1'b1;
                  state   <= WRITE;
               end else begin
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               prog_we <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_rom) begin
      if (!rst_n) begin
         dl_q       <= 1'b0;
         dwnld_busy <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         dl_q       <= downloading;
         dwnld_busy <= downloading || !fifo_empty || (state != IDLE);
         if (dl_rise)       dropped <= drop_now;
         else if (drop_now) dropped <= 1'b1;
      end
   end

`ifdef JTFRAME_PROG_SUM_EN
   always_ff @(posedge clk_rom) begin
      if (!rst_n)       prog_sum <= 16'd0;
      else if (dl_rise) prog_sum <= pop ? {8'd0, out_q.data} : 16'd0;
      else if (pop)     prog_sum <= prog_sum + {8'd0, out_q.data};
   end
`endif

endmodule

// File: tb/tb_jtframe_prog_pack.sv
// tb/tb_jtframe_prog_pack.sv - directed bench for jtframe_prog_pack (three parameterisations)
module tb_jtframe_prog_pack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        downloading = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_data = '0;
   logic        ioctl_wr = 1'b0;
   logic [2:0]  wr_en = 3'b0;
   logic [2:0]  wr_i;

   logic [21:0] p_addr [3];
   logic [7:0]  p_data [3];
   logic [1:0]  p_mask [3];
   logic [1:0]  p_bank [3];
   logic        p_we   [3];
   logic        p_rdy  [3];
   logic        busy   [3];
   logic        drp    [3];
   logic [15:0] psum   [3];

   int          lat  [3];
   logic        hold [3];
   int          cnt  [3];
   logic [33:0] wlog [3][32];
   int          wcnt [3];
   int          n_tests = 0;
   int          n_fail = 0;
   int          b;

   always #5 clk = ~clk;
   assign wr_i = {3{ioctl_wr}} & wr_en;

   jtframe_prog_pack u_dut0 (
      .clk_rom(clk), .rst_n(rst_n), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(wr_i[0]),
      .prog_addr(p_addr[0]), .prog_data(p_data[0]), .prog_mask(p_mask[0]),
      .prog_bank(p_bank[0]), .prog_we(p_we[0]), .prog_rdy(p_rdy[0]),
      .dwnld_busy(busy[0]), .dropped(drp[0])
`ifdef JTFRAME_PROG_SUM_EN
      , .prog_sum(psum[0])
`endif
   );

   jtframe_prog_pack #(.SWAB(1)) u_dut1 (
      .clk_rom(clk), .rst_n(rst_n), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(wr_i[1]),
      .prog_addr(p_addr[1]), .prog_data(p_data[1]), .prog_mask(p_mask[1]),
      .prog_bank(p_bank[1]), .prog_we(p_we[1]), .prog_rdy(p_rdy[1]),
      .dwnld_busy(busy[1]), .dropped(drp[1])
`ifdef JTFRAME_PROG_SUM_EN
      , .prog_sum(psum[1])
`endif
   );

   jtframe_prog_pack #(.HEADER(2)) u_dut2 (
      .clk_rom(clk), .rst_n(rst_n), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(wr_i[2]),
      .prog_addr(p_addr[2]), .prog_data(p_data[2]), .prog_mask(p_mask[2]),
      .prog_bank(p_bank[2]), .prog_we(p_we[2]), .prog_rdy(p_rdy[2]),
      .dwnld_busy(busy[2]), .dropped(drp[2])
`ifdef JTFRAME_PROG_SUM_EN
      , .prog_sum(psum[2])
`endif
   );

   task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] ent(input logic [1:0] bk, input logic [21:0] ad,
                                       input logic [1:0] mk, input logic [7:0] dt);
      return {2'b00, bk, ad, mk, dt};
   endfunction

   // SDRAM model: acknowledges lat cycles after prog_we rises and logs the word
   initial for (int i = 0; i < 3; i++) begin
      lat[i] = 3; hold[i] = 1'b0; cnt[i] = 0; wcnt[i] = 0; p_rdy[i] = 1'b0;
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (p_rdy[i]) begin
            p_rdy[i] = 1'b0;
            cnt[i]   = 0;
            check("we_end", 36'(p_we[i]), 36'd0);
         end else if (p_we[i] && !hold[i]) begin
            cnt[i]++;
            if (cnt[i] >= lat[i]) begin
               p_rdy[i] = 1'b1;
               if (wcnt[i] < 32) wlog[i][wcnt[i]] = {p_bank[i], p_addr[i], p_mask[i], p_data[i]};
               wcnt[i]++;
            end
         end else begin
            cnt[i] = 0;
         end
      end
   end

   task automatic wr_byte(input logic [24:0] ad, input logic [7:0] dt, input logic [2:0] en);
      ioctl_addr = ad; ioctl_data = dt; wr_en = en; ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0; wr_en = 3'b0;
      @(negedge clk);
   endtask

   task automatic wait_writes(input int i, input int n);
      int t = 0;
      while (wcnt[i] < n && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      check("wr_cnt", 36'(wcnt[i]), 36'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_we",   36'(p_we[0]),   36'd0);
      check("rst_mask", 36'(p_mask[0]), 36'h3);
      check("rst_word", 36'({p_bank[0], p_addr[0], p_data[0]}), 36'd0);
      check("rst_busy", 36'(busy[0]),   36'd0);
      check("rst_drop", 36'(drp[0]),    36'd0);
      rst_n = 1'b1;
      @(negedge clk);
      downloading = 1'b1;
      @(negedge clk);

      wr_byte(25'd0, 8'h11, 3'b001);
      check("lat_k1", 36'(p_we[0]), 36'd0);
      @(negedge clk);
      check("lat_k2", 36'(p_we[0]), 36'd1);
      check("first_out", 36'({p_bank[0], p_addr[0], p_mask[0], p_data[0]}), ent(2'd0, 22'd0, 2'b10, 8'h11));
      wr_byte(25'd1, 8'h22, 3'b001);
      wait_writes(0, 2);
      check("t1_w0", 36'(wlog[0][0]), ent(2'd0, 22'd0, 2'b10, 8'h11));
      check("t1_w1", 36'(wlog[0][1]), ent(2'd0, 22'd0, 2'b01, 8'h22));

      wr_byte(25'h10_0004, 8'h33, 3'b001);
      wr_byte(25'h0F_FFFF, 8'h34, 3'b001);
      wr_byte(25'hAF_FFFF, 8'h35, 3'b001);
      wr_byte(25'h30_0001, 8'h44, 3'b010);
      wr_byte(25'hB0_0000, 8'h45, 3'b010);
      wait_writes(0, 5);
      check("t2_bank1", 36'(wlog[0][2]), ent(2'd1, 22'd2, 2'b10, 8'h33));
      check("t2_top0",  36'(wlog[0][3]), ent(2'd0, 22'h7FFFF, 2'b01, 8'h34));
      check("t2_top3",  36'(wlog[0][4]), ent(2'd3, 22'h3FFFFF, 2'b01, 8'h35));
      check("t2_drop0", 36'(drp[0]), 36'd0);
      check("t2_swab_cnt", 36'(wcnt[1]), 36'd1);
      check("t2_swab",  36'(wlog[1][0]), ent(2'd3, 22'd0, 2'b10, 8'h44));
      check("t2_ovf",   36'(drp[1]), 36'd1);

      for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'hA0 + 8'(i), 3'b100);
      wait_writes(2, 2);
      check("t3_w0", 36'(wlog[2][0]), ent(2'd0, 22'd0, 2'b10, 8'hA2));
      check("t3_w1", 36'(wlog[2][1]), ent(2'd0, 22'd0, 2'b01, 8'hA3));
      check("t3_drop", 36'(drp[2]), 36'd0);

      hold[0] = 1'b1;
      b = wcnt[0];
      wr_byte(25'h40, 8'h50, 3'b001);
      @(negedge clk);
      check("t4_present", 36'({p_we[0], p_data[0]}), 36'h150);
      for (int i = 1; i < 8; i++) wr_byte(25'h40 + 25'(i), 8'h50 + 8'(i), 3'b001);
      check("t4_full_nodrop", 36'(drp[0]), 36'd0);
      wr_byte(25'h48, 8'h58, 3'b001);
      check("t4_drop", 36'(drp[0]), 36'd1);
      check("t4_held", 36'(wcnt[0]), 36'(b));
      downloading = 1'b0;
      lat[0] = 1;
      hold[0] = 1'b0;
      wait_writes(0, b + 8);
      for (int i = 0; i < 8; i++)
         check("t4_wr", 36'(wlog[0][b+i]),
               ent(2'd0, 22'(i / 2 + 32), (i % 2 == 1) ? 2'b01 : 2'b10, 8'h50 + 8'(i)));
      for (int t = 0; t < 50 && busy[0]; t++) @(negedge clk);
      check("t4_busy_fall", 36'(busy[0]), 36'd0);

      downloading = 1'b1;
      @(negedge clk);
      check("t5_drop_clr", 36'(drp[0]), 36'd0);
      hold[0] = 1'b1;
      for (int i = 0; i < 4; i++) wr_byte(25'h60 + 25'(i), 8'h70 + 8'(i), 3'b001);
      check("t5_we_pre", 36'(p_we[0]), 36'd1);
      b = wcnt[0];
      rst_n = 1'b0;
      downloading = 1'b0;
      @(negedge clk);
      check("t5_we_rst",   36'(p_we[0]),   36'd0);
      check("t5_busy_rst", 36'(busy[0]),   36'd0);
      check("t5_mask_rst", 36'(p_mask[0]), 36'h3);
      rst_n = 1'b1;
      hold[0] = 1'b0;
      repeat (20) @(negedge clk);
      check("t5_no_writes", 36'(wcnt[0]), 36'(b));
      check("t5_we_idle",   36'(p_we[0]), 36'd0);
      check("t5_busy_idle", 36'(busy[0]), 36'd0);

`ifdef JTFRAME_PROG_SUM_EN
      lat[0] = 2;
      downloading = 1'b1;
      @(negedge clk);
      wr_byte(25'd0, 8'hFF, 3'b001);
      wr_byte(25'd1, 8'h02, 3'b001);
      wr_byte(25'd2, 8'h10, 3'b001);
      wait_writes(0, b + 3);
      check("t6_sum", 36'(psum[0]), 36'h0111);
      downloading = 1'b0;
      @(negedge clk);
      downloading = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_sum_clr", 36'(psum[0]), 36'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
